// File: rtl/cricket_pkg.sv
// Shared types and constants for the cricket game datapath and control blocks.
// Holds the bat swing state encoding, timing defaults and screen bounds.
package cricket_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SWING    = 2'd1,
    COOLDOWN = 2'd2
  } swing_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_HOLD_FRAMES     = 6;
  localparam int DEF_COOLDOWN_FRAMES = 30;
  localparam int SIM_DEBOUNCE_CYCLES = 4;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces an active-low pushbutton, emitting a one-cycle press pulse.
// Latency: 2 sync + DEBOUNCE_CYCLES cycles from a clean key fall; no backpressure, the pulse is fire-and-forget.
module key_debouncer
  import cricket_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [DB_W-1:0] cnt;
  logic            flip;

  assign flip = (sync2 != level) && (cnt == DB_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      // Only a released->pressed flip is an event; releases are silent.
      press <= flip && !sync2;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bat_strike_ctrl.sv
// Bat swing controller: debounced press starts a frame-timed strike, then a cooldown.
// Latency: strike rises 1 cycle after the press pulse; presses while busy are dropped, not queued.
module bat_strike_ctrl
  import cricket_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_FRAMES     = DEF_HOLD_FRAMES,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             swing_key,
  input  logic             frame_tick,
  input  logic             game_active,
  output logic             strike,
  output logic             swing_start,
  output logic             busy,
  output logic [CNT_W-1:0] swing_count
);

  localparam int FMAX = (HOLD_FRAMES > COOLDOWN_FRAMES) ? HOLD_FRAMES : COOLDOWN_FRAMES;
  localparam int FC_W = $clog2(FMAX + 1);
  localparam logic [FC_W-1:0]  HOLD_LAST = FC_W'(HOLD_FRAMES);
  localparam logic [FC_W-1:0]  COOL_LAST = FC_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  swing_state_t     state, state_n;
  logic [FC_W-1:0]  fcnt, fcnt_n, fcnt_inc;
  logic [CNT_W-1:0] count_n;
  logic             press;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clock (clock),
    .resetn(resetn),
    .key_n (swing_key),
    .press (press)
  );

  assign fcnt_inc = fcnt + 1'b1;

  // A tick on the edge that enters a state is consumed by the previous state, so it is never counted twice.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    count_n = swing_count;
    if (!game_active) begin
      state_n = IDLE;
      fcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          fcnt_n = '0;
          if (press) begin
            state_n = SWING;
            if (swing_count != CNT_MAX) count_n = swing_count + 1'b1;
          end
        end
        SWING: begin
          if (frame_tick) begin
            if (fcnt_inc == HOLD_LAST) begin
              fcnt_n = '0;
              if (COOLDOWN_FRAMES == 0) state_n = IDLE;
              else                      state_n = COOLDOWN;
            end else begin
              fcnt_n = fcnt_inc;
            end
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (fcnt_inc == COOL_LAST) begin
              fcnt_n  = '0;
              state_n = IDLE;
            end else begin
              fcnt_n = fcnt_inc;
            end
          end
        end
        default: begin
          state_n = IDLE;
          fcnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      fcnt        <= '0;
      strike      <= 1'b0;
      swing_start <= 1'b0;
      busy        <= 1'b0;
      swing_count <= '0;
    end else begin
      state       <= state_n;
      fcnt        <= fcnt_n;
      strike      <= (state_n == SWING);
      swing_start <= (state_n == SWING) && (state != SWING);
      busy        <= (state_n != IDLE);
      swing_count <= count_n;
    end
  end

endmodule
